imem_fetch_responder: RTL and testbench



---
 rtl/imem_pkg.sv | 23 ++
 rtl/imem_line_array.sv | 45 ++++
 rtl/imem_fetch_responder.sv | 127 ++++++++++++
 tb/tb_imem_fetch_responder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types, constants and address-field helpers for the instruction-fetch responder.
package imem_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MISS = 1'b1
  } state_e;

  localparam logic [31:0] ZERO_INSTR = 32'h0000_0000;

  // Word index into a buffer of 'lines' entries; addresses are byte addresses.
  function automatic logic [63:0] line_idx(input logic [63:0] addr, input int lines);
    return (addr >> 2) & (64'(lines) - 64'd1);
  endfunction

  function automatic logic [63:0] line_tag(input logic [63:0] addr, input int lines,
                                           input int addr_w);
    logic [63:0] mask;
    mask = (addr_w >= 64) ? ~64'd0 : ((64'd1 << addr_w) - 64'd1);
    return (addr & mask) >> ($clog2(lines) + 2);
  endfunction

endpackage

// File: rtl/imem_line_array.sv
// Direct-mapped valid/tag/data storage: combinational read, one write port, clear-all.
module imem_line_array #(
  parameter int LINES = 16,
  parameter int TAG_W = 26,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  logic [LINES-1:0] valid_r;
  logic [TAG_W-1:0] tag_r  [LINES];
  logic [31:0]      data_r [LINES];

  assign rd_valid = valid_r[rd_idx];
  assign rd_tag   = tag_r[rd_idx];
  assign rd_data  = data_r[rd_idx];

  // Valid bits: a clear on the same edge as a refill leaves the line invalid.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid_r <= {LINES{1'b0}};
    end else if (wr_en) begin
      valid_r[wr_idx] <= 1'b1;
    end
  end

  // Tag and data payload are not reset; valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_r[wr_idx]  <= wr_tag;
      data_r[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: direct-mapped buffer in front of a req/ack backing memory,
// same-cycle hits, miss stall with refill forwarding, hit/miss counters.
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              invalidate,
  output logic [31:0]       instr_out,
  output logic              fetch_stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  state_e            state_r, state_next_s;
  logic [ADDR_W-1:0] miss_addr_r;
  logic [31:0]       hit_count_r, miss_count_r;

  logic [IDX_W-1:0]  pc_idx_s, miss_idx_s;
  logic [TAG_W-1:0]  pc_tag_s, miss_tag_s;
  logic              rd_valid_s;
  logic [TAG_W-1:0]  rd_tag_s;
  logic [31:0]       rd_data_s;
  logic              wr_en_s, hit_s, miss_s;

  assign pc_idx_s   = IDX_W'(line_idx(64'(pc_addr), LINES));
  assign pc_tag_s   = TAG_W'(line_tag(64'(pc_addr), LINES, ADDR_W));
  assign miss_idx_s = IDX_W'(line_idx(64'(miss_addr_r), LINES));
  assign miss_tag_s = TAG_W'(line_tag(64'(miss_addr_r), LINES, ADDR_W));

  imem_line_array #(
    .LINES (LINES),
    .TAG_W (TAG_W),
    .IDX_W (IDX_W)
  ) u_lines (
    .clk      (clk),
    .rst      (rst),
    .clear    (invalidate),
    .rd_idx   (pc_idx_s),
    .rd_valid (rd_valid_s),
    .rd_tag   (rd_tag_s),
    .rd_data  (rd_data_s),
    .wr_en    (wr_en_s),
    .wr_idx   (miss_idx_s),
    .wr_tag   (miss_tag_s),
    .wr_data  (mem_rdata)
  );

  assign mem_addr   = {miss_addr_r[ADDR_W-1:2], 2'b00};
  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;

  // Lookup, refill handshake and forwarding mux.
  always_comb begin
    state_next_s = state_r;
    instr_out    = ZERO_INSTR;
    fetch_stall  = 1'b1;
    mem_req      = 1'b0;
    wr_en_s      = 1'b0;
    hit_s        = 1'b0;
    miss_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rd_valid_s && (rd_tag_s == pc_tag_s)) begin
          instr_out   = rd_data_s;
          fetch_stall = 1'b0;
          hit_s       = 1'b1;
        end else begin
          miss_s       = 1'b1;
          state_next_s = ST_MISS;
        end
      end
      ST_MISS: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          wr_en_s      = 1'b1;
          state_next_s = ST_IDLE;
          // A PC that moved during the miss gets no forward; IDLE re-looks it up.
          if (pc_addr[ADDR_W-1:2] == miss_addr_r[ADDR_W-1:2]) begin
            instr_out   = mem_rdata;
            fetch_stall = 1'b0;
          end else begin
            fetch_stall = 1'b1;
          end
        end else begin
          fetch_stall = 1'b1;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, captured miss address and wrapping event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      miss_addr_r  <= {ADDR_W{1'b0}};
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else begin
      state_r <= state_next_s;
      if (miss_s) begin
        miss_addr_r  <= pc_addr;
        miss_count_r <= miss_count_r + 32'd1;
      end else begin
        miss_addr_r  <= miss_addr_r;
      end
      if (hit_s) begin
        hit_count_r <= hit_count_r + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder: misses, hits, conflicts, invalidate, reset mid-miss.
module tb_imem_fetch_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_addr;
  logic        invalidate;
  logic [31:0] instr_out;
  logic        fetch_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int vectors = 0;
  int miscompares = 0;

  imem_fetch_responder #(.LINES(16), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_addr     (pc_addr),
    .invalidate  (invalidate),
    .instr_out   (instr_out),
    .fetch_stall (fetch_stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .hit_count   (hit_count),
    .miss_count  (miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled just after the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full miss: IDLE miss cycle, 'waits' MISS cycles without ack, then ack with forward.
  task automatic do_miss(input logic [31:0] addr, input int waits, input logic [31:0] data);
    int stalls;
    stalls  = 0;
    pc_addr = addr;
    #1;
    chk("idle_miss_stall", {31'd0, fetch_stall}, 32'd1);
    chk("idle_miss_instr", instr_out, 32'd0);
    chk("idle_miss_req", {31'd0, mem_req}, 32'd0);
    if (fetch_stall) stalls++;
    cyc();
    for (int i = 0; i < waits; i++) begin
      #1;
      chk("miss_wait_req", {31'd0, mem_req}, 32'd1);
      chk("miss_wait_addr", mem_addr, {addr[31:2], 2'b00});
      chk("miss_wait_instr", instr_out, 32'd0);
      if (fetch_stall) stalls++;
      cyc();
    end
    mem_ack   = 1'b1;
    mem_rdata = data;
    #1;
    chk("ack_req", {31'd0, mem_req}, 32'd1);
    chk("ack_addr", mem_addr, {addr[31:2], 2'b00});
    chk("ack_fwd_instr", instr_out, data);
    chk("ack_fwd_stall", {31'd0, fetch_stall}, 32'd0);
    chk("stall_cycles", 32'(stalls), 32'(1 + waits));
    cyc();
    mem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc_addr = 32'h0; invalidate = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);

    // First fetch of 0x0: two MISS cycles before ack -> three stall cycles.
    do_miss(32'h0000_0000, 2, 32'h0000_0013);
    chk("miss_count_1", miss_count, 32'd1);
    chk("hit_count_0", hit_count, 32'd0);

    pc_addr = 32'h0;
    #1;
    chk("hit0_instr", instr_out, 32'h0000_0013);
    chk("hit0_stall", {31'd0, fetch_stall}, 32'd0);
    chk("hit0_req", {31'd0, mem_req}, 32'd0);
    cyc();
    chk("hit_count_1", hit_count, 32'd1);

    // Conflict on index 0: 0x40 evicts 0x0, then 0x0 misses again.
    do_miss(32'h0000_0040, 1, 32'hAAAA_0040);
    do_miss(32'h0000_0000, 0, 32'h0000_0013);
    chk("miss_count_3", miss_count, 32'd3);
    pc_addr = 32'h0;
    #1;
    chk("refill0_instr", instr_out, 32'h0000_0013);
    chk("refill0_stall", {31'd0, fetch_stall}, 32'd0);
    cyc();
    chk("hit_count_2", hit_count, 32'd2);

    // Ack on the first MISS cycle: exactly one stall cycle (checked inside).
    do_miss(32'h0000_0104, 0, 32'hDEAD_BEEF);
    chk("miss_count_4", miss_count, 32'd4);

    // Invalidate coinciding with the refill of 0x8: forward still happens.
    pc_addr = 32'h0000_0008;
    #1;
    chk("inv_idle_stall", {31'd0, fetch_stall}, 32'd1);
    cyc();
    mem_ack = 1'b1; mem_rdata = 32'h0080_0093; invalidate = 1'b1;
    #1;
    chk("inv_fwd_instr", instr_out, 32'h0080_0093);
    chk("inv_fwd_stall", {31'd0, fetch_stall}, 32'd0);
    cyc();
    mem_ack = 1'b0; invalidate = 1'b0;
    chk("miss_count_5", miss_count, 32'd5);
    do_miss(32'h0000_0008, 0, 32'h0080_0093);
    do_miss(32'h0000_0000, 0, 32'h0000_0013);
    chk("miss_count_7", miss_count, 32'd7);

    // PC moves during MISS: forward suppressed, fill still lands at the miss address.
    pc_addr = 32'h0000_0020;
    #1;
    chk("pv_idle_stall", {31'd0, fetch_stall}, 32'd1);
    cyc();
    pc_addr = 32'h0000_0024; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    chk("pv_no_fwd_stall", {31'd0, fetch_stall}, 32'd1);
    chk("pv_no_fwd_instr", instr_out, 32'd0);
    cyc();
    mem_ack = 1'b0;
    #1;
    chk("pv_relookup_stall", {31'd0, fetch_stall}, 32'd1);
    pc_addr = 32'h0000_0020;
    #1;
    chk("pv_fill_instr", instr_out, 32'h1234_5678);
    chk("pv_fill_stall", {31'd0, fetch_stall}, 32'd0);
    cyc();
    chk("hit_count_3", hit_count, 32'd3);
    chk("miss_count_8", miss_count, 32'd8);

    // Reset in the middle of a miss; a late ack must be ignored.
    pc_addr = 32'h0000_0030;
    cyc();
    #1;
    chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    pc_addr = 32'h0;
    #1;
    chk("post_rst_req", {31'd0, mem_req}, 32'd0);
    chk("post_rst_hits", hit_count, 32'd0);
    chk("post_rst_misses", miss_count, 32'd0);
    chk("post_rst_miss0", {31'd0, fetch_stall}, 32'd1);
    pc_addr = 32'h0000_0030; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("late_ack_stall", {31'd0, fetch_stall}, 32'd1);
    chk("late_ack_instr", instr_out, 32'd0);
    cyc();
    mem_ack = 1'b0;
    #1;
    chk("late_ack_req", {31'd0, mem_req}, 32'd1);
    chk("late_ack_misses", miss_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
